uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit byte path (tx_data_in / write_tx_data / tx_buffer_full of the rs232_uart instance) between NUM_REQ message sources.
- Typical sources: menu text, record/playback status strings and debug dumps.
- Arbitration is per message and round-robin. A granted requester owns the UART until it hands over a byte flagged last.
- Throttles writes so the UART TX FIFO never overflows.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, 2, index width, equal to clog2(NUM_REQ).
- TIMEOUT_CYCLES, 1000000, stall limit for the optional watchdog (10 ms at 100 MHz).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  requester i wants to send a message; sampled only in IDLE.
- req_data  in  8*NUM_REQ  flattened byte lanes; lane i is bits [8i+7:8i].
- req_valid  in  NUM_REQ  lane i byte valid.
- req_last  in  NUM_REQ  lane i byte is the final byte of its message.
- req_ready  out  NUM_REQ  lane i byte accepted this cycle (combinational).
- grant  out  NUM_REQ  one-hot owner, registered.
- busy  out  1  high when state is not IDLE.
- tx_data  out  8  connects to the UART tx_data_in.
- write_tx_data  out  1  single-cycle UART write strobe.
- tx_buffer_full  in  1  from the UART.
- timeout_err  out  1  one-cycle pulse; exists only with the optional feature.

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high.
- Reset values:
  - state=IDLE.
  - grant=0, busy=0.
  - tx_data=8'h00, write_tx_data=0.
  - timeout_err=0.
  - RR pointer last_idx=NUM_REQ-1, so requester 0 has first priority.
- States: IDLE and SEND.
- IDLE:
  - If req is nonzero, pick the first set bit scanning upward from last_idx+1 with wrap.
  - Next cycle: grant gets that one-hot value, state=SEND, last_idx is not yet updated.
  - If req is 0, stay in IDLE.
- SEND:
  - req_ready[i] = (i==owner) & ~tx_buffer_full & ~write_tx_data.
  - All non-owner ready bits are 0.
  - req, and req_valid on non-owner lanes, are ignored.
- Transfer: occurs when req_valid[g] & req_ready[g] in cycle N.
  - Cycle N+1: tx_data=req_data lane g, write_tx_data=1.
  - write_tx_data falls in N+2 unless a new transfer occurs. A new transfer cannot occur, because ready includes ~write_tx_data.
  - Net rate is at most one write per 2 cycles. This covers the one-cycle lag between a write and tx_buffer_full updating.
- Last byte: a transfer with req_last[g] set triggers, in cycle N+1:
  - grant=0, state=IDLE, last_idx=g.
  - The final write strobe still occurs in N+1.
  - New arbitration evaluates in IDLE starting at N+1.
  - The earliest next grant is N+2. Minimum gap between messages is 1 idle cycle.
- tx_buffer_full high: no acceptance. The byte stays pending at the requester, and the grant is held indefinitely (without the option).
- Simultaneous requests: exactly one grant, by round-robin. A requester dropping req while ungranted loses nothing.
- Requester drops req mid-message: this has no effect. Only req_last ends ownership.
- Reset mid-message: all outputs go to reset values in the next cycle. A partial message is abandoned, and no write strobe follows reset.
- NUM_REQ=1 degenerates to a pass-through gate with a 1-cycle arbitration bubble.

Optional Feature:
- Macro: UART_TX_ARBITER_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on each transfer and on entry to SEND, and increments while SEND has no transfer. This includes cycles where tx_buffer_full blocks.
  - At TIMEOUT_CYCLES-1: force IDLE, grant=0, last_idx=g, and pulse timeout_err for 1 cycle.
  - No write strobe is issued on abort.
- Without the macro: the timeout_err port and counter are absent, and the grant is held until req_last.

Decomposition:
- Package uart_tx_arbiter_pkg:
  - state encoding (ST_IDLE=1'b0, ST_SEND=1'b1).
  - default NUM_REQ.
  - TIMEOUT_CYCLES default.
  - counter width constant TMO_W=20.
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: req, last_idx.
  - Outputs: onehot, idx, any.
  - Instantiated once.

Test Plan:
- Single message: req=4'b0001, lane0 sends 8'h48, 8'h69 (last), tx_buffer_full=0.
  - Expect grant=0001 one cycle after req.
  - Two write_tx_data pulses with tx_data 48 then 69, at least 2 cycles apart.
  - busy=0 after the last byte.
- Round-robin: req=4'b1111 held, each requester sends a 1-byte last message.
  - Expect grant order 0001, 0010, 0100, 1000, 0001.
  - No interleaving of lanes.
- Backpressure: hold tx_buffer_full=1 for 20 cycles mid-message.
  - Expect req_ready=0 and no write strobes for those cycles.
  - Transfer resumes the cycle after full falls.
- Ownership: requester 2 is granted and requester 0 raises req mid-message.
  - Expect requester 0 granted only after lane 2's last byte.
- Reset mid-message: assert reset during SEND after 3 bytes.
  - Expect grant=0, write_tx_data=0, busy=0 the next cycle.
  - Requester 0 wins the first arbitration after reset.
- With UART_TX_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=16: granted lane holds req_valid=0.
  - Expect timeout_err pulse 16 cycles after the grant, then grant=0.
  - Next requester served.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared state encoding and default sizing for the UART TX arbiter.
package uart_tx_arbiter_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_e;
    localparam int NUM_REQ_DEF        = 4;
    localparam int TIMEOUT_CYCLES_DEF = 1000000;
    localparam int TMO_W              = 20;
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester lanes plus UART byte path; timeout_err exists only with UART_TX_ARBITER_TIMEOUT_EN.
interface uart_tx_arbiter_if
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   grant;
    logic                 busy;
    logic [7:0]           tx_data;
    logic                 write_tx_data;
    logic                 tx_buffer_full;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
    logic                 timeout_err;
`endif

    modport slave (
        input  req, req_data, req_valid, req_last, tx_buffer_full,
`ifdef UART_TX_ARBITER_TIMEOUT_EN
        output timeout_err,
`endif
        output req_ready, grant, busy, tx_data, write_tx_data
    );

    modport master (
        output req, req_data, req_valid, req_last, tx_buffer_full,
`ifdef UART_TX_ARBITER_TIMEOUT_EN
        input  timeout_err,
`endif
        input  req_ready, grant, busy, tx_data, write_tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// uart_tx_arbiter_rr_pick: combinational round-robin pick, scanning upward from last_idx_i+1 with wrap.
module uart_tx_arbiter_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_idx_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!any_o && req_i[IW'((int'(last_idx_i) + k) % N)]) begin
                any_o = 1'b1;
                idx_o = IW'((int'(last_idx_i) + k) % N);
            end
        end
        onehot_o = any_o ? N'(1) << idx_o : '0;
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: per-message round-robin sharing of one UART TX byte path, one write per 2 cycles max.
// Optional stall watchdog with UART_TX_ARBITER_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = NUM_REQ_DEF,
    parameter int IDX_W          = 2,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input logic              clk,
    input logic              reset,
    uart_tx_arbiter_if.slave bus
);
    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d, pick_onehot;
    logic [IDX_W-1:0]     owner_q, owner_d, last_idx_q, last_idx_d, pick_idx;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 wr_q, wr_d, pick_any, xfer;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
    logic [TMO_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;
    assign bus.timeout_err = err_q;
`endif

    uart_tx_arbiter_rr_pick #(.N(NUM_REQ), .IW(IDX_W)) u_rr_pick (
        .req_i      (bus.req),
        .last_idx_i (last_idx_q),
        .onehot_o   (pick_onehot),
        .idx_o      (pick_idx),
        .any_o      (pick_any)
    );

    // ~wr_q spaces writes so tx_buffer_full has a cycle to reflect the previous byte
    assign bus.req_ready     = grant_q & {NUM_REQ{~bus.tx_buffer_full & ~wr_q}};
    assign xfer              = |(bus.req_valid & bus.req_ready);
    assign bus.grant         = grant_q;
    assign bus.busy          = state_q == ST_SEND;
    assign bus.tx_data       = tx_data_q;
    assign bus.write_tx_data = wr_q;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        last_idx_d = last_idx_q;
        tx_data_d  = tx_data_q;
        wr_d       = 1'b0;
        if (state_q == ST_IDLE) begin
            if (pick_any) begin
                state_d = ST_SEND;
                grant_d = pick_onehot;
                owner_d = pick_idx;
            end
        end else if (xfer) begin
            tx_data_d = bus.req_data[{owner_q, 3'b000} +: 8];
            wr_d      = 1'b1;
            if (bus.req_last[owner_q]) begin
                state_d    = ST_IDLE;
                grant_d    = '0;
                last_idx_d = owner_q;
            end
        end
`ifdef UART_TX_ARBITER_TIMEOUT_EN
        cnt_d = (state_q == ST_SEND && !xfer) ? cnt_q + 1'b1 : '0;
        err_d = state_q == ST_SEND && !xfer && cnt_q == TMO_W'(TIMEOUT_CYCLES - 1);
        if (err_d) begin
            state_d    = ST_IDLE;
            grant_d    = '0;
            last_idx_d = owner_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            last_idx_q <= IDX_W'(NUM_REQ - 1);
            tx_data_q  <= 8'h00;
            wr_q       <= 1'b0;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            last_idx_q <= last_idx_d;
            tx_data_q  <= tx_data_d;
            wr_q       <= wr_d;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of grant order, write spacing, backpressure, ownership and reset.
// Timeout scenario runs only when UART_TX_ARBITER_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    logic [7:0] wlog[$];
    int         wcyc[$];

    uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

    uart_tx_arbiter #(.NUM_REQ(4), .IDX_W(2), .TIMEOUT_CYCLES(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.write_tx_data) begin
            wlog.push_back(bus.tx_data);
            wcyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req = '0;
        bus.req_valid = '0;
        bus.req_last = '0;
        bus.req_data = '0;
        bus.tx_buffer_full = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic send_byte(input int lane, input logic [7:0] d, input logic last);
        int t = 0;
        bus.req_data[lane*8 +: 8] = d;
        bus.req_valid[lane] = 1'b1;
        bus.req_last[lane] = last;
        #1;
        while (!bus.req_ready[lane] && t < 100) begin
            tick();
            t++;
        end
        if (t >= 100) check("ready_wait", 0, 1);
        tick();
        bus.req_valid[lane] = 1'b0;
        bus.req_last[lane] = 1'b0;
    endtask

    task automatic wait_grant();
        int t = 0;
        while (bus.grant == '0 && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) check("grant_wait", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0;
        int bad;
        logic [3:0] e;
        do_reset();
        reset = 1'b1;
        check("rst_grant", bus.grant, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_txdata", bus.tx_data, 0);
        check("rst_wr", bus.write_tx_data, 0);
        reset = 1'b0;

        // single message on lane 0
        bus.req = 4'b0001;
        tick();
        bus.req = '0;
        check("t1_grant", bus.grant, 4'b0001);
        check("t1_busy", bus.busy, 1);
        n0 = wlog.size();
        send_byte(0, 8'h48, 1'b0);
        send_byte(0, 8'h69, 1'b1);
        check("t1_busy_end", bus.busy, 0);
        check("t1_grant_end", bus.grant, 0);
        check("t1_wr_last", bus.write_tx_data, 1);
        tick();
        check("t1_nwrites", wlog.size() - n0, 2);
        check("t1_byte0", wlog[n0], 8'h48);
        check("t1_byte1", wlog[n0+1], 8'h69);
        check("t1_spacing", (wcyc[n0+1] - wcyc[n0]) >= 2, 1);

        // round robin with all requesters asserting
        do_reset();
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            e = 4'b0001 << (i % 4);
            wait_grant();
            check("t2_grant", bus.grant, e);
            bus.req_data = 32'h44332211;
            bus.req_valid = 4'b1111;
            bus.req_last = 4'b1111;
            #1;
            check("t2_ready", bus.req_ready, e);
            tick();
            bus.req_valid = '0;
            bus.req_last = '0;
            check("t2_wr", bus.write_tx_data, 1);
            check("t2_data", bus.tx_data, 8'h11 * ((i % 4) + 1));
            check("t2_release", bus.grant, 0);
        end
        bus.req = '0;
        tick();
        tick();

        // backpressure mid-message on lane 1
        do_reset();
        bus.req = 4'b0010;
        tick();
        bus.req = '0;
        check("t3_grant", bus.grant, 4'b0010);
        send_byte(1, 8'h11, 1'b0);
        bus.tx_buffer_full = 1'b1;
        bus.req_data[15:8] = 8'h22;
        bus.req_valid[1] = 1'b1;
        bus.req_last[1] = 1'b1;
        tick();
        n0 = wlog.size();
        bad = 0;
        repeat (20) begin
            if (bus.req_ready != 0 || bus.write_tx_data) bad++;
            tick();
        end
        check("t3_stall", bad, 0);
        check("t3_nowrites", wlog.size() - n0, 0);
        check("t3_held", bus.grant, 4'b0010);
        bus.tx_buffer_full = 1'b0;
        #1;
        check("t3_ready", bus.req_ready, 4'b0010);
        tick();
        bus.req_valid = '0;
        bus.req_last = '0;
        check("t3_wr", bus.write_tx_data, 1);
        check("t3_data", bus.tx_data, 8'h22);
        check("t3_busy", bus.busy, 0);

        // ownership held by lane 2 while lane 0 asks
        do_reset();
        bus.req = 4'b0100;
        tick();
        bus.req = '0;
        check("t4_grant", bus.grant, 4'b0100);
        n0 = wlog.size();
        send_byte(2, 8'hA1, 1'b0);
        send_byte(2, 8'hA2, 1'b0);
        bus.req = 4'b0001;
        send_byte(2, 8'hA3, 1'b0);
        check("t4_hold", bus.grant, 4'b0100);
        send_byte(2, 8'hA4, 1'b1);
        check("t4_release", bus.grant, 0);
        wait_grant();
        check("t4_next", bus.grant, 4'b0001);
        check("t4_nwrites", wlog.size() - n0, 4);
        check("t4_lastbyte", wlog[n0+3], 8'hA4);
        bus.req = '0;
        send_byte(0, 8'hB0, 1'b1);

        // reset in the middle of a message
        do_reset();
        bus.req = 4'b0001;
        tick();
        bus.req = '0;
        send_byte(0, 8'hC1, 1'b0);
        send_byte(0, 8'hC2, 1'b0);
        send_byte(0, 8'hC3, 1'b0);
        reset = 1'b1;
        tick();
        check("t5_grant", bus.grant, 0);
        check("t5_wr", bus.write_tx_data, 0);
        check("t5_busy", bus.busy, 0);
        check("t5_txdata", bus.tx_data, 0);
        n0 = wlog.size();
        reset = 1'b0;
        tick();
        tick();
        check("t5_nostrobe", wlog.size() - n0, 0);
        bus.req = 4'b1111;
        tick();
        check("t5_first", bus.grant, 4'b0001);
        bus.req = '0;
        send_byte(0, 8'hC4, 1'b1);

`ifdef UART_TX_ARBITER_TIMEOUT_EN
        // watchdog abort when the owner never presents a byte
        do_reset();
        bus.req = 4'b0011;
        tick();
        check("t6_grant", bus.grant, 4'b0001);
        n0 = wlog.size();
        bad = 0;
        while (!bus.timeout_err && bad < 40) begin
            tick();
            bad++;
        end
        check("t6_delay", bad, 16);
        check("t6_grant_clr", bus.grant, 0);
        check("t6_busy", bus.busy, 0);
        tick();
        check("t6_pulse", bus.timeout_err, 0);
        wait_grant();
        check("t6_next", bus.grant, 4'b0010);
        check("t6_nostrobe", wlog.size() - n0, 0);
        bus.req = '0;
        send_byte(1, 8'hD1, 1'b1);
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
